ysyx_23060096_exec_seq: RTL and testbench
=========================================

Name: ysyx_23060096_exec_seq

Overview:
Multi-cycle sequencer that drives the single-issue RV32 datapath (pc, control/imm generation, register file, ALU) over handshaked instruction and data memory ports. Owns the PC and instruction registers, steps each instruction through fetch, execute, memory and writeback, gates register-file writes, and halts on ebreak. Sits between the core datapath and the memory bus adapters.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 255, memory-response watchdog limit; used only with the optional feature

Ports:
clk  in  1  core clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
imem_req_valid  out  1  instruction fetch request
imem_req_ready  in  1  fetch request accepted
imem_req_addr  out  32  fetch address; always equals pc
imem_resp_valid  in  1  instruction data valid
imem_resp_data  in  32  fetched instruction
ir  out  32  instruction register, feeds the decoder and immediate generator
pc  out  32  current PC
dec_is_load  in  1  decoded from ir
dec_is_store  in  1  decoded from ir
dec_is_ebreak  in  1  ir == 32'h0010_0073
dec_reg_wr  in  1  decoder register-write request
next_pc  in  32  datapath-computed next PC (pc+4, branch or jump target)
dmem_req_valid  out  1  data request
dmem_req_ready  in  1  data request accepted
dmem_req_we  out  1  1 = store, 0 = load
dmem_resp_valid  in  1  load data valid / store acknowledged
rf_we  out  1  gated register-file write enable
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  sequencer stopped
err  out  1  fault indicator; valid while halted

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction): state=FETCH, pc=RESET_PC, ir=0, halted=0, err=0. While rst=1, imem_req_valid, dmem_req_valid, rf_we and retire are forced to 0. Any outstanding bus transaction is abandoned.
- FETCH: imem_req_valid=1 and imem_req_addr=pc. Valid and address are held stable until imem_req_ready. On ready, go to IWAIT.
- IWAIT: on imem_resp_valid, latch ir<=imem_resp_data and go to EXEC. A response that arrives in any other state is ignored.
- EXEC: one cycle for decode and ALU settling. Transitions are checked in this priority order:
  - dec_is_ebreak -> HALT, with a retire pulse in this cycle and pc unchanged.
  - dec_is_load or dec_is_store -> MREQ.
  - otherwise -> WB.
- MREQ: dmem_req_valid=1 and dmem_req_we=dec_is_store, held until dmem_req_ready. Then go to MWAIT.
- MWAIT: on dmem_resp_valid, go to WB. Stores also wait for the acknowledge.
- WB: rf_we = dec_reg_wr & ~dec_is_store; retire=1. Then:
  - if next_pc[1:0] != 0: go to HALT with err=1, pc unchanged.
  - else: pc<=next_pc and go to FETCH.
- HALT: absorbing state until reset. All request valids are 0, pc and ir are frozen, halted=1.
- rf_we is asserted only in WB and never for more than one cycle per instruction.
- Latency with zero-wait memory (ready in the request cycle, response the next cycle):
  - ALU or branch instruction: 4 cycles (FETCH, IWAIT, EXEC, WB).
  - load or store: 6 cycles.
- Request and response on the same edge: a response is never taken in the request state; memory must respond no earlier than the cycle after acceptance.
- PC wrap-around: next_pc=32'hFFFF_FFFC is accepted as is; no overflow handling.

Optional Feature:
YSYX_23060096_BUS_TIMEOUT_EN:
- When defined: an 8-bit+ wait counter clears on entry to IWAIT or MWAIT and increments each cycle spent waiting. If it reaches TIMEOUT_CYCLES without a response, go to HALT with err=1 and no retire pulse.
- When undefined: no counter is built; IWAIT and MWAIT wait indefinitely, and err is set only by a misaligned PC.

Test Plan:
1. Release reset; imem ready=1; response the next cycle with addi (dec_reg_wr=1); next_pc=32'h8000_0004 -> imem_req_addr=32'h8000_0000, rf_we high exactly in cycle 4, retire in cycle 4, pc=32'h8000_0004 in cycle 5.
2. Hold imem_req_ready=0 for 3 cycles -> imem_req_valid stays 1 with address 32'h8000_0000 stable; no retire; advances on the 4th cycle.
3. Load (dec_is_load=1, dec_reg_wr=1), dmem ready after 2 wait cycles, response 1 cycle later -> dmem_req_we=0, rf_we only in WB, retire 8 cycles after fetch start.
4. Store (dec_is_store=1, dec_reg_wr=1) -> dmem_req_we=1, rf_we stays 0, retire asserted, pc advances.
5. Fetch 32'h0010_0073 with dec_is_ebreak=1 -> retire pulse, halted=1 next cycle, no further imem_req_valid for 20 cycles; then assert rst for 1 cycle -> pc=32'h8000_0000, fetch resumes.
6. next_pc=32'h8000_0006 -> halted=1, err=1, pc unchanged. With YSYX_23060096_BUS_TIMEOUT_EN defined, withhold imem_resp_valid for 255 cycles -> halted=1, err=1, no retire.

Source files
------------

// File: rtl/ysyx_23060096_exec_seq_if.sv
// Instruction and data memory handshake bundle for the exec sequencer.
// master: sequencer side (drives requests, receives readies/responses).
// slave : memory/bus-adapter side.
//   imem_req_valid/ready/addr   instruction fetch request channel
//   imem_resp_valid/data        instruction fetch response
//   dmem_req_valid/ready/we     data request channel (we=1 store, 0 load)
//   dmem_resp_valid             load data valid / store acknowledge
interface ysyx_23060096_exec_seq_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic        dmem_resp_valid;

  modport master (
    output imem_req_valid, imem_req_addr, dmem_req_valid, dmem_req_we,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           dmem_req_ready, dmem_resp_valid
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dmem_req_valid, dmem_req_we,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           dmem_req_ready, dmem_resp_valid
  );
endinterface

// File: rtl/ysyx_23060096_exec_seq.sv
// Multi-cycle sequencer for the single-issue RV32 datapath. Owns pc and ir,
// steps each instruction through FETCH, IWAIT, EXEC, (MREQ, MWAIT,) WB and
// stops in HALT on ebreak, a misaligned next_pc or (optionally) a bus timeout.
// Ports:
//   clk, rst          core clock; asynchronous active-high reset
//   bus (master)      imem/dmem handshake bundle
//   ir, pc            instruction register and current pc to the datapath
//   dec_*             decoder outputs derived from ir
//   next_pc           datapath-computed next pc
//   rf_we             gated register-file write enable (WB only)
//   retire            one-cycle pulse per completed instruction
//   halted, err       sequencer stopped; fault indicator valid while halted
// Optional feature macro: YSYX_23060096_BUS_TIMEOUT_EN adds a watchdog on
// IWAIT/MWAIT that halts with err after TIMEOUT_CYCLES waiting cycles.
module ysyx_23060096_exec_seq #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  ysyx_23060096_exec_seq_if.master        bus,
  output logic [31:0]                     ir,
  output logic [31:0]                     pc,
  input  logic                            dec_is_load,
  input  logic                            dec_is_store,
  input  logic                            dec_is_ebreak,
  input  logic                            dec_reg_wr,
  input  logic [31:0]                     next_pc,
  output logic                            rf_we,
  output logic                            retire,
  output logic                            halted,
  output logic                            err
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_IWAIT,
    S_EXEC,
    S_MREQ,
    S_MWAIT,
    S_WB,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        err_q, err_d;

  logic        imem_v, dmem_v, dmem_we, rf_we_c, retire_c;

`ifdef YSYX_23060096_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout;

  // Wait states are only entered from FETCH/MREQ, where the counter is held
  // at zero, so it naturally starts from zero on every entry.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == S_IWAIT || state_q == S_MWAIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  assign timeout = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    err_d    = err_q;
    imem_v   = 1'b0;
    dmem_v   = 1'b0;
    dmem_we  = 1'b0;
    rf_we_c  = 1'b0;
    retire_c = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_v = 1'b1;
        if (bus.imem_req_ready) begin
          state_d = S_IWAIT;
        end
      end

      S_IWAIT: begin
        if (bus.imem_resp_valid) begin
          ir_d    = bus.imem_resp_data;
          state_d = S_EXEC;
        end
`ifdef YSYX_23060096_BUS_TIMEOUT_EN
        else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
`endif
      end

      S_EXEC: begin
        if (dec_is_ebreak) begin
          retire_c = 1'b1;
          state_d  = S_HALT;
        end else if (dec_is_load || dec_is_store) begin
          state_d = S_MREQ;
        end else begin
          state_d = S_WB;
        end
      end

      S_MREQ: begin
        dmem_v  = 1'b1;
        dmem_we = dec_is_store;
        if (bus.dmem_req_ready) begin
          state_d = S_MWAIT;
        end
      end

      S_MWAIT: begin
        if (bus.dmem_resp_valid) begin
          state_d = S_WB;
        end
`ifdef YSYX_23060096_BUS_TIMEOUT_EN
        else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
`endif
      end

      S_WB: begin
        rf_we_c  = dec_reg_wr & ~dec_is_store;
        retire_c = 1'b1;
        if (next_pc[1:0] != 2'b00) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  // State already sits in FETCH during reset, so the request/strobe outputs
  // are explicitly masked while rst is high.
  assign bus.imem_req_valid = imem_v & ~rst;
  assign bus.imem_req_addr  = pc_q;
  assign bus.dmem_req_valid = dmem_v & ~rst;
  assign bus.dmem_req_we    = dmem_we;
  assign rf_we              = rf_we_c & ~rst;
  assign retire             = retire_c & ~rst;
  assign halted             = (state_q == S_HALT);
  assign err                = err_q;
  assign pc                 = pc_q;
  assign ir                 = ir_q;

endmodule

// File: tb/tb_ysyx_23060096_exec_seq.sv
module tb_ysyx_23060096_exec_seq;
  logic        clk;
  logic        rst;
  logic [31:0] ir, pc, next_pc;
  logic        dec_is_load, dec_is_store, dec_is_ebreak, dec_reg_wr;
  logic        rf_we, retire, halted, err;

  int unsigned n_checks;
  int unsigned n_errors;

  ysyx_23060096_exec_seq_if bus ();

  ysyx_23060096_exec_seq #(
    .RESET_PC       (32'h8000_0000),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .ir            (ir),
    .pc            (pc),
    .dec_is_load   (dec_is_load),
    .dec_is_store  (dec_is_store),
    .dec_is_ebreak (dec_is_ebreak),
    .dec_reg_wr    (dec_reg_wr),
    .next_pc       (next_pc),
    .rf_we         (rf_we),
    .retire        (retire),
    .halted        (halted),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    dec_is_load   = 1'b0;
    dec_is_store  = 1'b0;
    dec_is_ebreak = 1'b0;
    dec_reg_wr    = 1'b0;
    next_pc       = '0;
  endtask

  task automatic do_reset();
    clear_dec();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.dmem_req_ready  = 1'b0;
    bus.dmem_resp_valid = 1'b0;
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Enters in a FETCH cycle, leaves in the EXEC cycle with ir loaded.
  task automatic do_fetch(input int unsigned stall, input logic [31:0] instr,
                          input logic [31:0] exp_pc);
    clear_dec();
    bus.imem_req_ready = 1'b0;
    for (int unsigned i = 0; i < stall; i++) begin
      check("fetch_stall_valid", {31'b0, bus.imem_req_valid}, 32'd1);
      check("fetch_stall_addr", bus.imem_req_addr, exp_pc);
      check("fetch_stall_retire", {31'b0, retire}, 32'd0);
      tick();
    end
    bus.imem_req_ready = 1'b1;
    check("fetch_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("fetch_addr", bus.imem_req_addr, exp_pc);
    check("fetch_rf_we", {31'b0, rf_we}, 32'd0);
    tick();
    bus.imem_req_ready  = 1'b0;
    check("iwait_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check("iwait_retire", {31'b0, retire}, 32'd0);
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = instr;
    tick();
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    check("exec_ir", ir, instr);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    clear_dec();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.dmem_req_ready  = 1'b0;
    bus.dmem_resp_valid = 1'b0;
    #2;
    check("rst_imem_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check("rst_dmem_valid", {31'b0, bus.dmem_req_valid}, 32'd0);
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_ir", ir, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_rf_we", {31'b0, rf_we}, 32'd0);
    tick();
    rst = 1'b0;
    #1;

    // ALU instruction, zero-wait memory: WB in cycle 4, new pc in cycle 5
    do_fetch(0, 32'h0010_0093, 32'h8000_0000);
    dec_reg_wr = 1'b1;
    next_pc    = 32'h8000_0004;
    #1;
    check("alu_exec_rf_we", {31'b0, rf_we}, 32'd0);
    check("alu_exec_retire", {31'b0, retire}, 32'd0);
    tick();
    check("alu_wb_rf_we", {31'b0, rf_we}, 32'd1);
    check("alu_wb_retire", {31'b0, retire}, 32'd1);
    check("alu_wb_pc", pc, 32'h8000_0000);
    tick();
    check("alu_next_pc", pc, 32'h8000_0004);
    check("alu_next_rf_we", {31'b0, rf_we}, 32'd0);
    check("alu_next_retire", {31'b0, retire}, 32'd0);
    check("alu_next_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("alu_next_addr", bus.imem_req_addr, 32'h8000_0004);

    // Fetch stalled 3 cycles, then a nop without register write
    do_reset();
    do_fetch(3, 32'h0000_0013, 32'h8000_0000);
    next_pc = 32'h8000_0004;
    tick();
    check("nop_wb_retire", {31'b0, retire}, 32'd1);
    check("nop_wb_rf_we", {31'b0, rf_we}, 32'd0);
    tick();
    check("nop_pc", pc, 32'h8000_0004);

    // Load: dmem ready after 2 wait cycles, response one cycle later
    do_fetch(0, 32'h0000_2103, 32'h8000_0004);
    dec_is_load = 1'b1;
    dec_reg_wr  = 1'b1;
    next_pc     = 32'h8000_0008;
    #1;
    check("ld_exec_dvalid", {31'b0, bus.dmem_req_valid}, 32'd0);
    tick();
    for (int unsigned i = 0; i < 3; i++) begin
      check("ld_mreq_valid", {31'b0, bus.dmem_req_valid}, 32'd1);
      check("ld_mreq_we", {31'b0, bus.dmem_req_we}, 32'd0);
      check("ld_mreq_rf_we", {31'b0, rf_we}, 32'd0);
      check("ld_mreq_retire", {31'b0, retire}, 32'd0);
      if (i == 2) bus.dmem_req_ready = 1'b1;
      tick();
    end
    bus.dmem_req_ready = 1'b0;
    check("ld_mwait_valid", {31'b0, bus.dmem_req_valid}, 32'd0);
    check("ld_mwait_rf_we", {31'b0, rf_we}, 32'd0);
    check("ld_mwait_retire", {31'b0, retire}, 32'd0);
    bus.dmem_resp_valid = 1'b1;
    tick();
    bus.dmem_resp_valid = 1'b0;
    check("ld_wb_rf_we", {31'b0, rf_we}, 32'd1);
    check("ld_wb_retire", {31'b0, retire}, 32'd1);
    tick();
    check("ld_pc", pc, 32'h8000_0008);
    check("ld_after_rf_we", {31'b0, rf_we}, 32'd0);

    // Store: ack delayed one cycle; no register write
    do_fetch(0, 32'h0011_2023, 32'h8000_0008);
    dec_is_store = 1'b1;
    dec_reg_wr   = 1'b1;
    next_pc      = 32'h8000_000C;
    tick();
    bus.dmem_req_ready = 1'b1;
    check("st_mreq_valid", {31'b0, bus.dmem_req_valid}, 32'd1);
    check("st_mreq_we", {31'b0, bus.dmem_req_we}, 32'd1);
    tick();
    bus.dmem_req_ready = 1'b0;
    check("st_mwait_valid", {31'b0, bus.dmem_req_valid}, 32'd0);
    tick();
    check("st_mwait_hold_retire", {31'b0, retire}, 32'd0);
    bus.dmem_resp_valid = 1'b1;
    tick();
    bus.dmem_resp_valid = 1'b0;
    check("st_wb_rf_we", {31'b0, rf_we}, 32'd0);
    check("st_wb_retire", {31'b0, retire}, 32'd1);
    tick();
    check("st_pc", pc, 32'h8000_000C);

    // ebreak: retire in EXEC, then frozen until reset
    do_fetch(0, 32'h0010_0073, 32'h8000_000C);
    dec_is_ebreak = 1'b1;
    next_pc       = 32'h8000_0010;
    #1;
    check("ebreak_retire", {31'b0, retire}, 32'd1);
    check("ebreak_rf_we", {31'b0, rf_we}, 32'd0);
    tick();
    check("ebreak_halted", {31'b0, halted}, 32'd1);
    check("ebreak_err", {31'b0, err}, 32'd0);
    check("ebreak_retire_off", {31'b0, retire}, 32'd0);
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hDEAD_BEEF;
    for (int unsigned i = 0; i < 20; i++) begin
      check("halt_imem_valid", {31'b0, bus.imem_req_valid}, 32'd0);
      check("halt_pc", pc, 32'h8000_000C);
      tick();
    end
    check("halt_ir_frozen", ir, 32'h0010_0073);
    check("halt_still", {31'b0, halted}, 32'd1);
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst2_pc", pc, 32'h8000_0000);
    check("rst2_halted", {31'b0, halted}, 32'd0);
    check("rst2_imem_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    tick();
    rst = 1'b0;
    clear_dec();
    #1;
    check("rst2_resume_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("rst2_resume_addr", bus.imem_req_addr, 32'h8000_0000);
    check("rst2_ir", ir, 32'h0);

    // pc wrap target accepted as is
    do_fetch(0, 32'h0000_006F, 32'h8000_0000);
    dec_reg_wr = 1'b1;
    next_pc    = 32'hFFFF_FFFC;
    tick();
    tick();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_halted", {31'b0, halted}, 32'd0);

    // Misaligned next_pc: retire, then halt with err and pc unchanged
    do_fetch(0, 32'h0010_0093, 32'hFFFF_FFFC);
    dec_reg_wr = 1'b1;
    next_pc    = 32'h8000_0006;
    tick();
    check("mis_wb_retire", {31'b0, retire}, 32'd1);
    tick();
    check("mis_halted", {31'b0, halted}, 32'd1);
    check("mis_err", {31'b0, err}, 32'd1);
    check("mis_pc", pc, 32'hFFFF_FFFC);
    check("mis_imem_valid", {31'b0, bus.imem_req_valid}, 32'd0);

    do_reset();
    check("post_mis_err", {31'b0, err}, 32'd0);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
`ifdef YSYX_23060096_BUS_TIMEOUT_EN
    // No instruction response: 255 waiting cycles, then halt with err
    for (int unsigned i = 0; i < 255; i++) begin
      check("to_wait_halted", {31'b0, halted}, 32'd0);
      check("to_wait_retire", {31'b0, retire}, 32'd0);
      tick();
    end
    check("to_halted", {31'b0, halted}, 32'd1);
    check("to_err", {31'b0, err}, 32'd1);
    check("to_retire", {31'b0, retire}, 32'd0);
`else
    // Without the watchdog IWAIT waits indefinitely
    for (int unsigned i = 0; i < 300; i++) begin
      tick();
    end
    check("nowd_halted", {31'b0, halted}, 32'd0);
    check("nowd_err", {31'b0, err}, 32'd0);
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h1234_5678;
    tick();
    bus.imem_resp_valid = 1'b0;
    check("nowd_ir", ir, 32'h1234_5678);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
